// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared IO constants, capture FSM encoding, status word packing
// Contents:
//   RX_FIFO_DEPTH / RX_FIFO_AW : default FIFO geometry
//   IO_DATA_IDX / IO_CTRL_IDX  : CPU IO word indices of the RS-232 data and status/control words
//   cap_state_e                : capture FSM encoding
//   rs232_status_word()        : packs {level, ovf, rdy_tx, rdy} into the status IO word
package uart_rx_fifo_pkg;

    localparam int RX_FIFO_DEPTH = 16;
    localparam int RX_FIFO_AW    = 4;

    localparam int IO_DATA_IDX = 2;
    localparam int IO_CTRL_IDX = 3;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } cap_state_e;

    // level occupies bits [7 +: AW+1]; a 9-bit field covers the largest DEPTH of 256,
    // smaller depths simply leave the upper level bits zero.
    function automatic logic [31:0] rs232_status_word(
        input logic [8:0] lvl,
        input logic       ovf_flag,
        input logic       rdy_tx,
        input logic       rdy_rx
    );
        return {16'd0, lvl, 4'd0, ovf_flag, rdy_tx, rdy_rx};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - RS-232 receive byte FIFO with capture handshake and sticky overflow
// Ports:
//   clk      : system clock, all state on rising edge
//   rst      : asynchronous active-low reset
//   rx_data  : received byte from the receiver
//   rx_rdy   : receiver byte-valid level, held until acknowledged
//   rx_done  : one-cycle acknowledge pulse to the receiver
//   pop      : CPU read strobe of the data IO word
//   ovf_clr  : CPU write strobe of the control IO word, clears ovf
//   dout     : head-of-FIFO byte (fall-through), 0 when empty
//   rdy      : FIFO not empty
//   level    : occupancy 0..DEPTH
//   ovf      : sticky overflow flag
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int AW    = RX_FIFO_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    output logic          rx_done,
    input  logic          pop,
    input  logic          ovf_clr,
    output logic [7:0]    dout,
    output logic          rdy,
    output logic [AW:0]   level,
    output logic          ovf
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    cap_state_e    state_q, state_d;
    logic          rx_done_q, rx_done_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];

    logic capture;
    logic full;
    logic not_empty;
    logic do_pop;
    logic do_push;
    logic drop;

    always_comb begin
        state_d   = state_q;
        rx_done_d = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    capture   = 1'b1;
                    rx_done_d = 1'b1;
                    state_d   = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                // rx_rdy is a level: wait for it to drop so one byte is never taken twice
                if (!rx_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        not_empty = (level_q != '0);
        full      = (level_q == FULL_LEVEL);
        do_pop    = pop && not_empty;
        // a pop on the same edge frees the slot, so a full FIFO can still accept
        do_push   = capture && (!full || do_pop);
        drop      = capture && full && !do_pop;

        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end

        // a coincident overflow beats the clear strobe
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rx_done_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_done_q <= rx_done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    // storage is not reset; the level counter gates what the CPU can see
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rx_done = rx_done_q;
    assign rdy     = not_empty;
    assign level   = level_q;
    assign ovf     = ovf_q;
    assign dout    = not_empty ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_done;
    logic       pop;
    logic       ovf_clr;
    logic [7:0] dout;
    logic       rdy;
    logic [4:0] level;
    logic       ovf;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .rx_done (rx_done),
        .pop     (pop),
        .ovf_clr (ovf_clr),
        .dout    (dout),
        .rdy     (rdy),
        .level   (level),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rx_done === 1'b1) done_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b0; rx_rdy = 1'b0; pop = 1'b0; ovf_clr = 1'b0; rx_data = 8'h00;
        tick();
        tick();
        rst = 1'b1;
        tick();
        done_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy  = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_rdy = 1'b0; pop = 1'b0; ovf_clr = 1'b0; rx_data = 8'h00;
        #3;
        n_vec++; if (rdy !== 1'b0)   begin n_bad++; $display("FAIL reset_rdy got %b exp 0", rdy); end
        n_vec++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %h exp 00", dout); end
        n_vec++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level got %0d exp 0", level); end
        n_vec++; if (ovf !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        n_vec++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL reset_rx_done got %b exp 0", rx_done); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        send_byte(8'h5A);
        n_vec++; if (done_cnt !== 1)  begin n_bad++; $display("FAIL single_done_cnt got %0d exp 1", done_cnt); end
        n_vec++; if (rdy !== 1'b1)    begin n_bad++; $display("FAIL single_rdy got %b exp 1", rdy); end
        n_vec++; if (dout !== 8'h5A)  begin n_bad++; $display("FAIL single_dout got %h exp 5a", dout); end
        n_vec++; if (level !== 5'd1)  begin n_bad++; $display("FAIL single_level got %0d exp 1", level); end
        pop_one();
        n_vec++; if (rdy !== 1'b0)    begin n_bad++; $display("FAIL single_pop_rdy got %b exp 0", rdy); end
        n_vec++; if (dout !== 8'h00)  begin n_bad++; $display("FAIL single_pop_dout got %h exp 00", dout); end
        pop_one();
        n_vec++; if (level !== 5'd0)  begin n_bad++; $display("FAIL empty_pop_level got %0d exp 0", level); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) send_byte(8'(i));
        n_vec++; if (done_cnt !== 17) begin n_bad++; $display("FAIL ovf_done_cnt got %0d exp 17", done_cnt); end
        n_vec++; if (level !== 5'd16) begin n_bad++; $display("FAIL ovf_level got %0d exp 16", level); end
        n_vec++; if (ovf !== 1'b1)    begin n_bad++; $display("FAIL ovf_flag got %b exp 1", ovf); end
        for (int i = 0; i < 16; i++) begin
            n_vec++; if (dout !== 8'(i)) begin n_bad++; $display("FAIL ovf_order[%0d] got %h exp %h", i, dout, 8'(i)); end
            pop_one();
        end
        n_vec++; if (rdy !== 1'b0)    begin n_bad++; $display("FAIL ovf_drained_rdy got %b exp 0", rdy); end
        n_vec++; if (ovf !== 1'b1)    begin n_bad++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_vec++; if (ovf !== 1'b0)    begin n_bad++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
        rx_data = 8'hAA; rx_rdy = 1'b1; pop = 1'b1;
        tick();
        rx_rdy = 1'b0; pop = 1'b0;
        tick();
        n_vec++; if (level !== 5'd16) begin n_bad++; $display("FAIL fpp_level got %0d exp 16", level); end
        n_vec++; if (ovf !== 1'b0)    begin n_bad++; $display("FAIL fpp_ovf got %b exp 0", ovf); end
        for (int i = 0; i < 15; i++) begin
            n_vec++; if (dout !== 8'h21 + 8'(i)) begin n_bad++; $display("FAIL fpp_order[%0d] got %h exp %h", i, dout, 8'h21 + 8'(i)); end
            pop_one();
        end
        n_vec++; if (dout !== 8'hAA)  begin n_bad++; $display("FAIL fpp_new_byte got %h exp aa", dout); end
        n_vec++; if (level !== 5'd1)  begin n_bad++; $display("FAIL fpp_last_level got %0d exp 1", level); end
    endtask

    task automatic test_hold();
        do_reset();
        rx_data = 8'hC3; rx_rdy = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rx_rdy = 1'b0;
        tick();
        n_vec++; if (done_cnt !== 1)  begin n_bad++; $display("FAIL hold_done_cnt got %0d exp 1", done_cnt); end
        n_vec++; if (level !== 5'd1)  begin n_bad++; $display("FAIL hold_level got %0d exp 1", level); end
        n_vec++; if (dout !== 8'hC3)  begin n_bad++; $display("FAIL hold_dout got %h exp c3", dout); end
    endtask

    task automatic test_ovf_clr_coincide();
        do_reset();
        for (int i = 0; i < 17; i++) send_byte(8'h40 + 8'(i));
        n_vec++; if (ovf !== 1'b1)    begin n_bad++; $display("FAIL coin_pre_ovf got %b exp 1", ovf); end
        rx_data = 8'hEE; rx_rdy = 1'b1; ovf_clr = 1'b1;
        tick();
        rx_rdy = 1'b0; ovf_clr = 1'b0;
        n_vec++; if (ovf !== 1'b1)    begin n_bad++; $display("FAIL coin_set_wins got %b exp 1", ovf); end
        tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_vec++; if (ovf !== 1'b0)    begin n_bad++; $display("FAIL coin_clear got %b exp 0", ovf); end
        n_vec++; if (level !== 5'd16) begin n_bad++; $display("FAIL coin_level got %0d exp 16", level); end
        n_vec++; if (dout !== 8'h40)  begin n_bad++; $display("FAIL coin_head got %h exp 40", dout); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rx_data = 8'h77; rx_rdy = 1'b1;
        tick();
        n_vec++; if (rx_done !== 1'b1) begin n_bad++; $display("FAIL mid_ack got %b exp 1", rx_done); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done got %b exp 0", rx_done); end
        n_vec++; if (level !== 5'd0)  begin n_bad++; $display("FAIL mid_rst_level got %0d exp 0", level); end
        n_vec++; if (rdy !== 1'b0)    begin n_bad++; $display("FAIL mid_rst_rdy got %b exp 0", rdy); end
        n_vec++; if (dout !== 8'h00)  begin n_bad++; $display("FAIL mid_rst_dout got %h exp 00", dout); end
        tick();
        rst = 1'b1;
        done_cnt = 0;
        tick();
        rx_rdy = 1'b0;
        tick();
        tick();
        n_vec++; if (done_cnt !== 1)  begin n_bad++; $display("FAIL mid_recapture_done got %0d exp 1", done_cnt); end
        n_vec++; if (level !== 5'd1)  begin n_bad++; $display("FAIL mid_recapture_level got %0d exp 1", level); end
        n_vec++; if (dout !== 8'h77)  begin n_bad++; $display("FAIL mid_recapture_dout got %h exp 77", dout); end
    endtask

    initial begin
        done_cnt = 0;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_hold();
        test_ovf_clr_coincide();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, 16, number of byte entries (power of two, 2..256).
REQ-002 SHALL have parameter AW, 4, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  system clock (25 MHz CPU clock); all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx_data  input  8  received byte from the RS-232 receiver.
REQ-006 SHALL have port rx_rdy  input  1  receiver byte-valid level; held high until acknowledged.
REQ-007 SHALL have port rx_done  output  1  one-cycle acknowledge pulse to the receiver.
REQ-008 SHALL have port pop  input  1  CPU read strobe of the RS-232 data IO word.
REQ-009 SHALL have port ovf_clr  input  1  CPU write strobe of the RS-232 control IO word; clears the overflow flag.
REQ-010 SHALL have port dout  output  8  head-of-FIFO byte; 0 when empty.
REQ-011 SHALL have port rdy  output  1  FIFO not empty.
REQ-012 SHALL have port level  output  AW+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-014 SHALL implement a capture FSM with states IDLE and WAIT_LOW.
REQ-015 In IDLE with rx_rdy=1, SHALL assert rx_done for exactly one cycle and go to WAIT_LOW.
REQ-016 On that cycle, if not full or pop=1, SHALL write rx_data at the write pointer.
REQ-017 On that cycle, if full and pop=0, SHALL drop the byte, set ovf, and leave contents unchanged.
REQ-018 In WAIT_LOW, SHALL hold rx_done=0 and return to IDLE on the first cycle with rx_rdy=0; a stale rx_rdy is never captured twice.
REQ-019 SHALL present dout combinationally from the head entry (first-word fall-through); read latency is 0.
REQ-020 pop with rdy=1 SHALL advance the read pointer on that edge.
REQ-021 pop with rdy=0 SHALL be ignored, with no pointer or level change.
REQ-022 Simultaneous push and pop SHALL leave level unchanged; when empty, only the push takes effect.
REQ-023 Pointers SHALL be AW bits and wrap modulo DEPTH; level SHALL be an explicit counter, +1 on push only and -1 on pop only.
REQ-024 ovf SHALL remain set until ovf_clr=1; if ovf_clr and a new overflow coincide, ovf SHALL stay 1 (set wins).
REQ-025 rdy SHALL equal (level != 0); full SHALL be internal, equal to (level == DEPTH).
REQ-026 Storage SHALL be a register or distributed-RAM array without reset; the CPU sees only entries written since the last reset.

Reset
REQ-027 On rst=0, asynchronously: pointers 0, level 0, ovf 0, FSM IDLE, rx_done 0; hence rdy 0 and dout 0.
REQ-028 Reset asserted mid-handshake SHALL abort it; after release with rx_rdy still 1, the byte SHALL be captured as new.
REQ-029 Deassertion SHALL be usable synchronously to clk; no further synchronizer is internal to the block.

Structure
REQ-030 DEPTH default, the FSM state encoding (IDLE=0, WAIT_LOW=1) and the IO word indices (data=2, status/control=3) SHALL live in the shared IO package.
REQ-031 SHALL be one flat module; no sub-module, since FIFO storage and capture FSM are together under 200 lines.
REQ-032 The top level SHALL map the status word as {level, ovf, rdyTx, rdy} in bits [7+:AW+1], 2, 1, 0.

Verification
REQ-033 Reset then one rx_rdy pulse with 0x5A -> one rx_done pulse, rdy=1, dout=0x5A, level=1; pop -> rdy=0, dout=0.
REQ-034 17 bytes 0x00..0x10 with no pops (DEPTH=16) -> level=16, ovf=1, pops return 0x00..0x0F in order, then rdy=0.
REQ-035 FIFO full with push and pop on the same cycle -> level stays 16, ovf stays 0, new byte appears after 15 further pops.
REQ-036 rx_rdy held high for 10 cycles -> exactly one push and one rx_done.
REQ-037 ovf=1 with ovf_clr pulsed in the same cycle as another overflow -> ovf=1; next ovf_clr alone -> ovf=0.
REQ-038 rst asserted in WAIT_LOW with rx_rdy=1 -> all outputs reset immediately; after release, byte captured once, level=1.
